// File: rtl/simplerisc_seq_pkg.sv
// Shared types and constants for the multi-cycle stage sequencer.
// State encodings are fixed because the raw state is exported for debug.
package simplerisc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_OF   = 3'd2,
        ST_EX   = 3'd3,
        ST_MA   = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6
    } seq_state_e;

    localparam logic [4:0] OPC_HALT = 5'b11111;
    localparam int         EX_CNT_W = 4;

    // EX residency for the decoded instruction class; mul wins if both are set.
    function automatic logic [EX_CNT_W-1:0] ex_latency(input logic is_mul,
                                                       input logic is_div_or_mod,
                                                       input int   mul_lat,
                                                       input int   div_lat);
        if (is_mul) begin
            return EX_CNT_W'(mul_lat);
        end else if (is_div_or_mod) begin
            return EX_CNT_W'(div_lat);
        end
        return EX_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stage_sequencer_ex_latency_counter.sv
// Down-counter that sets how many cycles the sequencer stays in EX.
// Loaded on entry to EX; last_o marks the final EX cycle.
module ex_latency_counter
    import simplerisc_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [EX_CNT_W-1:0] load_val_i,
    input  logic                dec_i,
    output logic                last_o
);

    logic [EX_CNT_W-1:0] cnt_q;
    logic [EX_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero count is treated as final so EX can never lock up.
    assign last_o = (cnt_q <= EX_CNT_W'(1));

endmodule

// File: rtl/stage_sequencer.sv
// IF/OF/EX/MA/WB sequencer for a non-pipelined core, with HALT as a sink state.
// Optional perf counters (instr_cnt, cycle_cnt) exist only with STAGE_SEQ_PERF_CNT_EN.
module stage_sequencer
    import simplerisc_seq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [4:0]  opcode,
    input  logic        isLd,
    input  logic        isSt,
    input  logic        isMul,
    input  logic        isDiv,
    input  logic        isMod,
    input  logic        mem_ready,
    output logic        if_en,
    output logic        of_en,
    output logic        ex_en,
    output logic        ma_en,
    output logic        wb_en,
    output logic        pc_we,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  state
`ifdef STAGE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] cycle_cnt
`endif
);

    seq_state_e          state_q;
    seq_state_e          state_d;
    logic                ex_load;
    logic                ex_dec;
    logic                ex_last;
    logic [EX_CNT_W-1:0] ex_lat;

    assign ex_lat = ex_latency(isMul, isDiv | isMod, MUL_LAT, DIV_LAT);

    always_comb begin
        state_d = state_q;
        ex_load = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_IF;
            ST_IF:   state_d = ST_OF;
            ST_OF: begin
                if (opcode == OPC_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EX;
                    ex_load = 1'b1;
                end
            end
            // isLd/isSt only matter on the last EX cycle.
            ST_EX:   if (ex_last) state_d = (isLd || isSt) ? ST_MA : ST_WB;
            ST_MA:   if (mem_ready) state_d = ST_WB;
            ST_WB:   state_d = run ? ST_IF : ST_IDLE;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign ex_dec = (state_q == ST_EX) && !ex_last;

    ex_latency_counter u_ex_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ex_load),
        .load_val_i (ex_lat),
        .dec_i      (ex_dec),
        .last_o     (ex_last)
    );

    assign if_en  = (state_q == ST_IF);
    assign of_en  = (state_q == ST_OF);
    assign ex_en  = (state_q == ST_EX);
    assign ma_en  = (state_q == ST_MA);
    assign wb_en  = (state_q == ST_WB);
    assign pc_we  = (state_q == ST_WB);
    assign halted = (state_q == ST_HALT);
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign state  = state_q;

`ifdef STAGE_SEQ_PERF_CNT_EN
    logic [31:0] instr_cnt_q;
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (pc_we) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (busy)  cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign cycle_cnt = cycle_cnt_q;
`endif

endmodule
